// File: rtl/mux16_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mux16_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/mux16_datapath.sv
// Operand registers and accumulator; adds one shifted partial product per step.
module mux16_datapath #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [CW-1:0]      idx,
    input  logic [WIDTH-1:0]   ain,
    input  logic [WIDTH-1:0]   bin,
    output logic [2*WIDTH-1:0] acc
);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] addend;

    always_comb begin
        addend = '0;
        if (mplier[idx[CW-2:0]])
            addend = {{WIDTH{1'b0}}, mcand} << idx;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= ain;
            mplier <= bin;
            acc    <= '0;
        end else if (step) begin
            acc <= acc + addend;
        end
    end

endmodule

// File: rtl/mux16_multiplier.sv
// Radix-2 sequential multiplier: level-held start, one-cycle done pulse.
module mux16_multiplier
    import mux16_pkg::*;
#(
    parameter int WIDTH = mux16_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   ain,
    input  logic [WIDTH-1:0]   bin,
    output logic [2*WIDTH-1:0] yout,
    output logic               done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic               load;
    logic               step;

    assign load = (state == IDLE) && start;
    assign step = (state == RUN) && start;

    mux16_datapath #(
        .WIDTH(WIDTH),
        .CW   (CW)
    ) u_dp (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .step (step),
        .idx  (cnt),
        .ain  (ain),
        .bin  (bin),
        .acc  (acc)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            yout  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // a dropped start abandons the product silently
                    if (!start) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST)
                            state <= DONE;
                    end
                end
                DONE: begin
                    yout  <= acc;
                    done  <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (!start)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_multiplier.sv
// Scoreboard bench: stimulus queues expected products, monitor checks done/yout.
module tb_mux16_multiplier;

    typedef struct {
        logic [31:0] p;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [31:0] yout;
    logic        done;

    exp_t        q[$];
    logic [31:0] held_y = '0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    mux16_multiplier dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .ain  (ain),
        .bin  (bin),
        .yout (yout),
        .done (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: pops an expectation whenever done is seen.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done cyc=%0d yout=%h", cyc, yout);
            end else begin
                e = q.pop_front();
                held_y = e.p;
                checks++;
                if (cyc != e.due) begin
                    failures++;
                    $display("FAIL latency got_cyc=%0d want_cyc=%0d",
                             cyc, e.due);
                end
            end
        end else if (done !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL done_x got=%b want=0", done);
        end
        checks++;
        if (yout !== held_y) begin
            failures++;
            $display("FAIL yout cyc=%0d got=%h want=%h", cyc, yout, held_y);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // One request: load at next edge, hold start, optionally disturb operands.
    task automatic mul(input logic [15:0] a, input logic [15:0] b,
                       input int hold, input bit disturb);
        exp_t e;
        ain   = a;
        bin   = b;
        start = 1'b1;
        e.p   = 32'(a) * 32'(b);
        e.due = cyc + 18;
        q.push_back(e);
        if (disturb) begin
            tick(4);
            ain = 16'($urandom);
            bin = 16'($urandom);
            tick(hold - 4);
        end else begin
            tick(hold);
        end
        start = 1'b0;
        ain   = 16'($urandom);
        bin   = 16'($urandom);
        tick(2);
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        ain   = '0;
        bin   = '0;
        tick(100);
        rst_n = 1'b0;
        tick(2);

        mul(16'd89, 16'd33, 225, 1'b0);
        tick(5);

        mul(16'hFFFF, 16'hFFFF, 20, 1'b0);
        mul(16'h0000, 16'h1234, 20, 1'b0);
        mul(16'h0001, 16'hFFFF, 20, 1'b0);
        mul(16'h8000, 16'h8000, 20, 1'b0);
        mul(16'h00FF, 16'h0101, 19, 1'b1);

        // abort: start falls while RUN handles bit 8
        ain   = 16'h1234;
        bin   = 16'h5678;
        start = 1'b1;
        tick(9);
        start = 1'b0;
        tick(3);
        mul(16'd7, 16'd6, 20, 1'b0);

        // synchronous reset mid-RUN, with start still high
        ain   = 16'hABCD;
        bin   = 16'h1357;
        start = 1'b1;
        tick(6);
        rst_n = 1'b1;
        tick(1);
        q.delete();
        held_y = '0;
        tick(2);
        rst_n = 1'b0;
        start = 1'b0;
        tick(2);
        mul(16'd1000, 16'd999, 20, 1'b0);

        for (int k = 0; k < 40; k++) begin
            mul(16'($urandom), 16'($urandom),
                $urandom_range(18, 24), 1'($urandom));
            tick($urandom_range(0, 2));
        end

        tick(25);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending got=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
